// File: rtl/call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : call_stack_ctrl
// Purpose  : Sequencer between the instruction decoder and an external
//            return-address stack. It turns decoded call/return requests
//            into single-cycle push/pop strobes, forms the link address,
//            stalls fetch while a popped return address is in flight, and
//            tracks stack occupancy with sticky overflow/underflow flags.
// Ports    : clk        - rising-edge clock shared with the stack
//            rst        - synchronous active-high reset
//            call_req   - decoder: current instruction is a call
//            ret_req    - decoder: current instruction is a return
//            call_pc    - PC of the calling instruction
//            pop_data   - data output of the stack
//            push_sig   - push strobe to the stack (registered)
//            pop_sig    - pop strobe to the stack (registered)
//            push_data  - link address to the stack (registered)
//            stall      - hold PC and decoder (combinational)
//            ret_valid  - one-cycle pulse, ret_addr is valid
//            ret_addr   - return target for the next-PC mux (registered)
//            depth      - current occupancy
//            ovf_err    - sticky: call dropped because stack was full
//            unf_err    - sticky: return dropped because stack was empty
// Revision : 1.0 - initial release
// ============================================================================
module call_stack_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic [ADDR_W-1:0] call_pc,
    input  logic [ADDR_W-1:0] pop_data,
    output logic              push_sig,
    output logic              pop_sig,
    output logic [ADDR_W-1:0] push_data,
    output logic              stall,
    output logic              ret_valid,
    output logic [ADDR_W-1:0] ret_addr,
    output logic [CNT_W-1:0]  depth,
    output logic              ovf_err,
    output logic              unf_err
);

    localparam logic [1:0]       c_ST_IDLE   = 2'd0;
    localparam logic [1:0]       c_ST_POP    = 2'd1;
    localparam logic [1:0]       c_ST_WAIT   = 2'd2;
    localparam logic [CNT_W-1:0] c_DEPTH_MAX = CNT_W'(DEPTH);

    logic [1:0]        r_state_q,     w_state_d;
    logic              r_push_q,      w_push_d;
    logic              r_pop_q,       w_pop_d;
    logic [ADDR_W-1:0] r_push_data_q, w_push_data_d;
    logic              r_ret_valid_q, w_ret_valid_d;
    logic [ADDR_W-1:0] r_ret_addr_q,  w_ret_addr_d;
    logic [CNT_W-1:0]  r_depth_q,     w_depth_d;
    logic              r_ovf_q,       w_ovf_d;
    logic              r_unf_q,       w_unf_d;
    logic              w_stall;
    logic              w_not_empty;
    logic              w_not_full;

    assign w_not_empty = (r_depth_q != '0);
    assign w_not_full  = (r_depth_q < c_DEPTH_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_ST_IDLE;
            r_push_q      <= 1'b0;
            r_pop_q       <= 1'b0;
            r_push_data_q <= '0;
            r_ret_valid_q <= 1'b0;
            r_ret_addr_q  <= '0;
            r_depth_q     <= '0;
            r_ovf_q       <= 1'b0;
            r_unf_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_push_q      <= w_push_d;
            r_pop_q       <= w_pop_d;
            r_push_data_q <= w_push_data_d;
            r_ret_valid_q <= w_ret_valid_d;
            r_ret_addr_q  <= w_ret_addr_d;
            r_depth_q     <= w_depth_d;
            r_ovf_q       <= w_ovf_d;
            r_unf_q       <= w_unf_d;
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_push_d      = 1'b0;
        w_pop_d       = 1'b0;
        w_push_data_d = r_push_data_q;
        w_ret_valid_d = 1'b0;
        w_ret_addr_d  = r_ret_addr_q;
        w_depth_d     = r_depth_q;
        w_ovf_d       = r_ovf_q;
        w_unf_d       = r_unf_q;
        w_stall       = 1'b0;

        case (r_state_q)
            c_ST_IDLE: begin
                // While ret_valid is high the decoder still shows the
                // returning instruction, so its requests must not be
                // taken a second time.
                if (!r_ret_valid_q) begin
                    if (ret_req && w_not_empty) begin
                        // Return wins; a same-cycle call is discarded.
                        w_stall   = 1'b1;
                        w_state_d = c_ST_POP;
                        w_pop_d   = 1'b1;
                        w_depth_d = r_depth_q - CNT_W'(1);
                    end else begin
                        if (ret_req) begin
                            w_unf_d = 1'b1;
                        end
                        if (call_req) begin
                            if (w_not_full) begin
                                w_push_d      = 1'b1;
                                w_push_data_d = call_pc + ADDR_W'(1);
                                w_depth_d     = r_depth_q + CNT_W'(1);
                            end else begin
                                w_ovf_d = 1'b1;
                            end
                        end
                    end
                end
            end
            c_ST_POP: begin
                // Stack consumes pop_sig at the end of this cycle.
                w_stall   = 1'b1;
                w_state_d = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // Popped entry is now on pop_data.
                w_stall       = 1'b1;
                w_ret_addr_d  = pop_data;
                w_ret_valid_d = 1'b1;
                w_state_d     = c_ST_IDLE;
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    assign push_sig  = r_push_q;
    assign pop_sig   = r_pop_q;
    assign push_data = r_push_data_q;
    assign stall     = w_stall;
    assign ret_valid = r_ret_valid_q;
    assign ret_addr  = r_ret_addr_q;
    assign depth     = r_depth_q;
    assign ovf_err   = r_ovf_q;
    assign unf_err   = r_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_call_stack_ctrl
// Purpose  : Self-checking bench for call_stack_ctrl. Includes a simple
//            8-entry return-address stack behind the controller, a
//            queue-based reference model of the controller, a vector table
//            for the basic call/return/underflow sequences, directed
//            sequences for the multi-cycle corner cases, and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_call_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        call_req;
    logic        ret_req;
    logic [11:0] call_pc;
    logic [11:0] pop_data;
    logic        push_sig;
    logic        pop_sig;
    logic [11:0] push_data;
    logic        stall;
    logic        ret_valid;
    logic [11:0] ret_addr;
    logic [3:0]  depth;
    logic        ovf_err;
    logic        unf_err;

    call_stack_ctrl #(.ADDR_W(12), .DEPTH(8), .CNT_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .call_req  (call_req),
        .ret_req   (ret_req),
        .call_pc   (call_pc),
        .pop_data  (pop_data),
        .push_sig  (push_sig),
        .pop_sig   (pop_sig),
        .push_data (push_data),
        .stall     (stall),
        .ret_valid (ret_valid),
        .ret_addr  (ret_addr),
        .depth     (depth),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Return-address stack attached to the controller
    // ------------------------------------------------------------------
    logic [11:0] stk_mem [8];
    int          stk_sp;

    always @(posedge clk) begin
        if (rst) begin
            stk_sp   <= 0;
            pop_data <= 12'h000;
        end else if (push_sig) begin
            if (stk_sp < 8) begin
                stk_mem[stk_sp] <= push_data;
                stk_sp          <= stk_sp + 1;
            end
        end else if (pop_sig) begin
            if (stk_sp > 0) begin
                pop_data <= stk_mem[stk_sp-1];
                stk_sp   <= stk_sp - 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: list of link addresses plus a countdown of the
    // remaining stall cycles of an accepted return.
    // ------------------------------------------------------------------
    logic [11:0] m_q[$];
    int          m_busy;
    logic [11:0] m_pending;
    logic        m_push, m_pop, m_rv, m_ovf, m_unf;
    logic [11:0] m_pd, m_ra;
    logic        m_valid = 1'b0;

    logic        cur_r, cur_c, cur_t;
    logic [11:0] cur_pc;

    int total = 0;
    int bad   = 0;
    int push_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic model_stall(input logic t);
        return (m_busy > 0) || (!m_rv && t && (m_q.size() > 0));
    endfunction

    task automatic model_update();
        logic new_push, new_pop, new_rv;
        if (cur_r) begin
            m_q.delete();
            m_busy  = 0;
            m_push  = 0; m_pop = 0; m_rv = 0; m_ovf = 0; m_unf = 0;
            m_pd    = 12'h000; m_ra = 12'h000; m_pending = 12'h000;
            m_valid = 1'b1;
            return;
        end
        new_push = 0; new_pop = 0; new_rv = 0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                new_rv = 1;
                m_ra   = m_pending;
            end
        end else if (!m_rv) begin
            if (cur_t && m_q.size() > 0) begin
                m_pending = m_q.pop_back();
                new_pop   = 1;
                m_busy    = 2;
            end else begin
                if (cur_t) m_unf = 1;
                if (cur_c) begin
                    if (m_q.size() < 8) begin
                        m_pd = cur_pc + 12'd1;
                        m_q.push_back(m_pd);
                        new_push = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
        m_push = new_push;
        m_pop  = new_pop;
        m_rv   = new_rv;
    endtask

    // Drive one cycle's inputs mid-cycle and compare all outputs to the model.
    task automatic apply(input logic r, input logic c, input logic t, input logic [11:0] pc);
        @(negedge clk);
        rst = r; call_req = c; ret_req = t; call_pc = pc;
        cur_r = r; cur_c = c; cur_t = t; cur_pc = pc;
        #1;
        if (push_sig === 1'b1) push_cnt++;
        if (m_valid) begin
            chk("push_sig",  {31'd0, push_sig},  {31'd0, m_push});
            chk("pop_sig",   {31'd0, pop_sig},   {31'd0, m_pop});
            chk("push_data", {20'd0, push_data}, {20'd0, m_pd});
            chk("stall",     {31'd0, stall},     {31'd0, model_stall(t)});
            chk("ret_valid", {31'd0, ret_valid}, {31'd0, m_rv});
            chk("ret_addr",  {20'd0, ret_addr},  {20'd0, m_ra});
            chk("depth",     {28'd0, depth},     m_q.size());
            chk("ovf_err",   {31'd0, ovf_err},   {31'd0, m_ovf});
            chk("unf_err",   {31'd0, unf_err},   {31'd0, m_unf});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic cycle(input logic r, input logic c, input logic t, input logic [11:0] pc);
        apply(r, c, t, pc);
        tick();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 12'h000);
    endtask

    // Wait (bounded) for ret_valid, optionally holding ret_req, then check ret_addr.
    task automatic do_return(input string nm, input logic hold, input logic [11:0] exp_ra);
        logic        got = 1'b0;
        logic [11:0] seen = 12'h000;
        for (int n = 0; n < 8 && !got; n++) begin
            apply(1'b0, 1'b0, hold, 12'h000);
            if (ret_valid === 1'b1) begin
                got  = 1'b1;
                seen = ret_addr;
            end
            tick();
        end
        chk({nm, "_seen"}, {31'd0, got}, 32'd1);
        chk({nm, "_addr"}, {20'd0, seen}, {20'd0, exp_ra});
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        r, c, t;
        logic [11:0] pc;
        logic        chk_en;
        logic        push, pop;
        logic [11:0] pd;
        logic        stl, rv;
        logic [11:0] ra;
        logic [3:0]  d;
        logic        ovf, unf;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic r, input logic c, input logic t, input logic [11:0] pc,
                                input logic en, input logic push, input logic pop, input logic [11:0] pd,
                                input logic stl, input logic rv, input logic [11:0] ra,
                                input logic [3:0] d, input logic ovf, input logic unf);
        vec_t v;
        v.r = r; v.c = c; v.t = t; v.pc = pc; v.chk_en = en;
        v.push = push; v.pop = pop; v.pd = pd; v.stl = stl; v.rv = rv;
        v.ra = ra; v.d = d; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; call_req = 1'b0; ret_req = 1'b0; call_pc = 12'h000;

        //            r c t pc      en push pop pd      stl rv ra      d ovf unf
        tbl[0]  = mk(1,0,0,12'h000, 0, 0,0,12'h000, 0,0,12'h000, 0,0,0);
        tbl[1]  = mk(0,1,0,12'h010, 1, 0,0,12'h000, 0,0,12'h000, 0,0,0);
        tbl[2]  = mk(0,0,1,12'h000, 1, 1,0,12'h011, 1,0,12'h000, 1,0,0);
        tbl[3]  = mk(0,0,1,12'h000, 1, 0,1,12'h011, 1,0,12'h000, 0,0,0);
        tbl[4]  = mk(0,0,1,12'h000, 1, 0,0,12'h011, 1,0,12'h000, 0,0,0);
        tbl[5]  = mk(0,0,1,12'h000, 1, 0,0,12'h011, 0,1,12'h011, 0,0,0);
        tbl[6]  = mk(0,0,0,12'h000, 1, 0,0,12'h011, 0,0,12'h011, 0,0,0);
        tbl[7]  = mk(1,0,0,12'h000, 0, 0,0,12'h000, 0,0,12'h000, 0,0,0);
        tbl[8]  = mk(0,0,1,12'h000, 1, 0,0,12'h000, 0,0,12'h000, 0,0,0);
        tbl[9]  = mk(0,1,0,12'h003, 1, 0,0,12'h000, 0,0,12'h000, 0,0,1);
        tbl[10] = mk(0,0,1,12'h000, 1, 1,0,12'h004, 1,0,12'h000, 1,0,1);
        tbl[11] = mk(0,0,0,12'h000, 1, 0,1,12'h004, 1,0,12'h000, 0,0,1);
        tbl[12] = mk(0,0,0,12'h000, 1, 0,0,12'h004, 1,0,12'h000, 0,0,1);
        tbl[13] = mk(0,0,0,12'h000, 1, 0,0,12'h004, 0,1,12'h004, 0,0,1);
        tbl[14] = mk(0,0,0,12'h000, 1, 0,0,12'h004, 0,0,12'h004, 0,0,1);

        // Basic call/return, reset state, underflow with sticky flag
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].r, tbl[i].c, tbl[i].t, tbl[i].pc);
            if (tbl[i].chk_en) begin
                chk($sformatf("tbl%0d_push", i),  {31'd0, push_sig},  {31'd0, tbl[i].push});
                chk($sformatf("tbl%0d_pop", i),   {31'd0, pop_sig},   {31'd0, tbl[i].pop});
                chk($sformatf("tbl%0d_pdata", i), {20'd0, push_data}, {20'd0, tbl[i].pd});
                chk($sformatf("tbl%0d_stall", i), {31'd0, stall},     {31'd0, tbl[i].stl});
                chk($sformatf("tbl%0d_rv", i),    {31'd0, ret_valid}, {31'd0, tbl[i].rv});
                chk($sformatf("tbl%0d_raddr", i), {20'd0, ret_addr},  {20'd0, tbl[i].ra});
                chk($sformatf("tbl%0d_depth", i), {28'd0, depth},     {28'd0, tbl[i].d});
                chk($sformatf("tbl%0d_ovf", i),   {31'd0, ovf_err},   {31'd0, tbl[i].ovf});
                chk($sformatf("tbl%0d_unf", i),   {31'd0, unf_err},   {31'd0, tbl[i].unf});
            end
            tick();
        end

        // Fill to capacity, one overflowing call, then drain in LIFO order
        do_reset();
        push_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, 1'b1, 1'b0, (i < 8) ? 12'(12'h100 + i) : 12'hFFF);
            if (i > 0) chk("fill_pdata", {20'd0, push_data}, 32'h100 + i);
            tick();
        end
        apply(1'b0, 1'b0, 1'b0, 12'h000);
        chk("full_nopush", {31'd0, push_sig}, 32'd0);
        chk("full_ovf",    {31'd0, ovf_err},  32'd1);
        chk("full_depth",  {28'd0, depth},    32'd8);
        tick();
        chk("fill_pushes", push_cnt, 32'd8);
        for (int k = 0; k < 8; k++) begin
            do_return("drain", 1'b1, 12'(12'h108 - k));
        end
        apply(1'b0, 1'b0, 1'b0, 12'h000);
        chk("drain_depth", {28'd0, depth},   32'd0);
        chk("drain_ovf",   {31'd0, ovf_err}, 32'd1);
        tick();

        // Simultaneous call and return: return wins, call dropped silently
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 12'h0A4);
        cycle(1'b0, 1'b1, 1'b1, 12'h200);
        apply(1'b0, 1'b0, 1'b0, 12'h000);
        chk("both_nopush", {31'd0, push_sig}, 32'd0);
        chk("both_pop",    {31'd0, pop_sig},  32'd1);
        tick();
        do_return("both", 1'b0, 12'h0A5);
        apply(1'b0, 1'b0, 1'b0, 12'h000);
        chk("both_depth", {28'd0, depth},   32'd0);
        chk("both_ovf",   {31'd0, ovf_err}, 32'd0);
        tick();

        // Reset during the POP cycle aborts the return
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 12'h050);
        cycle(1'b0, 1'b0, 1'b1, 12'h000);
        apply(1'b1, 1'b0, 1'b0, 12'h000);
        chk("abort_pop_before", {31'd0, pop_sig}, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b0, 12'h000);
            chk("abort_rv",    {31'd0, ret_valid}, 32'd0);
            chk("abort_pop",   {31'd0, pop_sig},   32'd0);
            chk("abort_stall", {31'd0, stall},     32'd0);
            chk("abort_depth", {28'd0, depth},     32'd0);
            tick();
        end
        cycle(1'b0, 1'b1, 1'b0, 12'hFFF);
        apply(1'b0, 1'b0, 1'b0, 12'h000);
        chk("wrap_push",  {31'd0, push_sig},  32'd1);
        chk("wrap_pdata", {20'd0, push_data}, 32'h000);
        tick();

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic r, c, t;
            r = ($urandom_range(0, 79) == 0);
            c = ($urandom_range(0, 99) < 50);
            t = ($urandom_range(0, 99) < 35);
            cycle(r, c, t, 12'($urandom_range(0, 4095)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
Sequencer that sits between the instruction decoder and the 8-entry, 12-bit return-address stack.
- Converts decoded call and return requests into single-cycle push_sig/pop_sig pulses toward the stack.
- Computes the link address pushed on a call.
- Stalls the fetch path while a popped return address is in flight.
- Keeps its own occupancy count and flags overflow and underflow without ever driving an illegal stack operation.

Parameters:
ADDR_W, 12, width of PC and return address
DEPTH, 8, stack capacity in entries; must match the stack instance
CNT_W, 4, width of occupancy counter; must hold 0..DEPTH

Ports:
clk  input  1  rising-edge clock shared with the stack
rst  input  1  synchronous active-high reset
call_req  input  1  decoder: current instruction is a call
ret_req  input  1  decoder: current instruction is a return
call_pc  input  ADDR_W  PC of the calling instruction
pop_data  input  ADDR_W  data output of the stack
push_sig  output  1  push strobe to the stack (registered)
pop_sig  output  1  pop strobe to the stack (registered)
push_data  output  ADDR_W  link address to the stack (registered)
stall  output  1  hold PC and decoder (combinational)
ret_valid  output  1  one-cycle pulse: ret_addr is valid
ret_addr  output  ADDR_W  return target for next-PC mux (registered)
depth  output  CNT_W  current occupancy
ovf_err  output  1  sticky: call dropped because stack was full
unf_err  output  1  sticky: return dropped because stack was empty

Behaviour:
- Reset: rst sampled high at a clk edge forces state IDLE and zeroes every register: push_sig, pop_sig, push_data, ret_valid, ret_addr, depth, ovf_err, unf_err. stall is 0 after reset. After reset the controller treats the stack as empty; the system asserts rst only together with stack power-up initialisation.
- State machine: IDLE, POP, WAIT.
- IDLE, with the cycle ret_valid=1 excluded:
  - ret_req=1 and depth>0:
    - stall=1 combinationally in this cycle.
    - Next state POP.
    - pop_sig<=1, depth<=depth-1.
    - call_req in the same cycle is dropped; no push occurs and no flag is set.
  - ret_req=1 and depth=0:
    - unf_err<=1.
    - No pop, stall=0, stay IDLE.
    - A simultaneous call_req is processed normally (call rules below).
  - call_req=1 without a return accepted, and depth<DEPTH:
    - push_sig<=1, push_data<=call_pc+1 (mod 2^ADDR_W), depth<=depth+1.
    - No stall.
  - call_req=1 and depth=DEPTH:
    - No push, ovf_err<=1, depth unchanged.
  - Back-to-back calls push on consecutive cycles.
- POP (1 cycle):
  - pop_sig=1 and stall=1.
  - The stack samples pop_sig at the closing edge and presents the popped entry on pop_data afterwards.
  - Next state WAIT; pop_sig<=0.
- WAIT (1 cycle):
  - stall=1.
  - At the closing edge: ret_addr<=pop_data, ret_valid<=1, next state IDLE.
- ret_valid cycle:
  - State is IDLE, stall=0, ret_valid=1.
  - ret_req and call_req are ignored in this cycle because they still belong to the returning instruction.
  - ret_valid<=0 at the next edge. ret_addr holds its value until the next pop completes.
- Return latency: ret_req accepted in cycle C0; pop_sig high in C1; stall high in C0..C2; ret_valid high in C3.
- Requests in POP or WAIT are ignored; the requester is stalled.
- push_sig and pop_sig are never high in the same cycle. Each is high for exactly one cycle per accepted operation.
- depth never exceeds DEPTH or goes below 0. It updates on the same edge that raises push_sig or pop_sig.
- ovf_err and unf_err clear only on rst.
- Reset mid-operation: rst in POP or WAIT aborts the return. ret_valid is never raised for it, and depth=0 next cycle.

Test Plan:
1. rst; call_req=1, call_pc=0x010 for one cycle -> next cycle push_sig=1, push_data=0x011, depth=1, stall=0 throughout.
2. After test 1, ret_req=1 held until ret_valid -> stall=1 for 3 cycles; pop_sig=1 in the 2nd cycle only; 4th cycle ret_valid=1, ret_addr=0x011, depth=0, stall=0; no second pop.
3. Eight calls with call_pc 0x100..0x107 on consecutive cycles, then a 9th with 0xFFF -> 8 push pulses with data 0x101..0x108; 9th produces no push_sig; ovf_err=1; depth=8. Then 8 returns yield ret_addr 0x108 down to 0x101.
4. rst; ret_req=1 -> no pop_sig, stall=0, unf_err=1, depth=0; flag stays set across later valid call/return.
5. depth=1 holding 0x0A5; call_req=1 and ret_req=1 together with call_pc=0x200 -> no push, pop sequence runs, ret_addr=0x0A5, depth=0, ovf_err=0.
6. Return in progress: rst asserted in POP cycle -> following cycle pop_sig=0, stall=0, depth=0, ret_valid stays 0 for 5 cycles; call_pc=0xFFF call afterwards pushes 0x000 (wrap).
